// File: rtl/float64_pkg.sv
// Shared types and constants for the float64 datapath blocks.
// Holds the operand class codes, exception flag bits, field limits,
// the one-hot unpacker state encoding and the unpacked-operand payload.
package float64_pkg;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned EXP_W      = 13;
  localparam int unsigned BEXP_W     = 11;
  localparam int unsigned FRAC_W     = 52;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned STEP_W     = 3;
  localparam int unsigned FLAG_W     = 32;
  localparam int unsigned NORM_STEPS = 6;
  localparam int unsigned HIDDEN_POS = 62;

  localparam logic [BEXP_W-1:0] EXP_MAX = 11'd2047;

  localparam logic [FLAG_W-1:0] FLAG_INEXACT   = 32'd1;
  localparam logic [FLAG_W-1:0] FLAG_UNDERFLOW = 32'd4;
  localparam logic [FLAG_W-1:0] FLAG_OVERFLOW  = 32'd8;
  localparam logic [FLAG_W-1:0] FLAG_INVALID   = 32'd16;

  typedef enum logic [2:0] {
    CLS_ZERO      = 3'd0,
    CLS_SUBNORMAL = 3'd1,
    CLS_NORMAL    = 3'd2,
    CLS_INF       = 3'd3,
    CLS_QNAN      = 3'd4,
    CLS_SNAN      = 3'd5
  } class_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_NORM = 3'b010,
    S_DONE = 3'b100
  } state_t;

  // Operand in the packer's internal format.
  typedef struct packed {
    logic               sign;
    logic [EXP_W-1:0]   exp;
    logic [WORD_W-1:0]  sig;
    class_t             cls;
  } unpacked_t;

endpackage

// File: rtl/float64_subnorm_shifter.sv
// Iterative leading-zero normalizer for subnormal significands.
// Ports: ap_clk/ap_rst (sync, active-high); load captures frac as
// {0,frac}<<11 and clears the count; step applies shift stage step_idx
// (k = 32>>step_idx). m_nxt_c/cnt_nxt_c expose the post-step values so the
// caller can capture the final result on the same edge as the last step.
module float64_subnorm_shifter
  import float64_pkg::*;
(
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                load,
  input  logic [FRAC_W-1:0]   frac,
  input  logic                step,
  input  logic [STEP_W-1:0]   step_idx,
  output logic [WORD_W-1:0]   m_nxt_c,
  output logic [CNT_W-1:0]    cnt_nxt_c
);

  logic [WORD_W-1:0] m_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [6:0]        k;
  logic [WORD_W-1:0] top_mask;

  // Shift by k when the top k bits of m are all zero.
  always_comb begin
    k         = 7'd32 >> step_idx;
    top_mask  = ~({WORD_W{1'b1}} >> k);
    m_nxt_c   = m_q;
    cnt_nxt_c = cnt_q;
    if ((m_q & top_mask) == '0) begin
      m_nxt_c   = m_q << k;
      cnt_nxt_c = cnt_q + CNT_W'(k);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      m_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      m_q   <= WORD_W'(frac) << 11;
      cnt_q <= '0;
    end else if (step) begin
      m_q   <= m_nxt_c;
      cnt_q <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/unpack_float64.sv
// Multi-cycle IEEE-754 binary64 unpacker feeding the DF MUL datapath.
// Ports: ap_clk, ap_rst (sync, active-high); ap_start/ap_done/ap_idle/
// ap_ready block handshake; a = operand; float_exception_flag_i/_o/_o_ap_vld
// sticky flag side channel (INVALID added on signalling NaN);
// aSign/aExp/aSig/aClass = registered unpacked operand, valid from DONE
// until the next DONE. Subnormals take 6 extra NORM cycles.
module unpack_float64
  import float64_pkg::*;
(
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  output logic                ap_ready,
  input  logic [WORD_W-1:0]   a,
  input  logic [FLAG_W-1:0]   float_exception_flag_i,
  output logic [FLAG_W-1:0]   float_exception_flag_o,
  output logic                float_exception_flag_o_ap_vld,
  output logic                aSign,
  output logic [EXP_W-1:0]    aExp,
  output logic [WORD_W-1:0]   aSig,
  output logic [2:0]          aClass
);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q;
  logic                sign_q;
  unpacked_t           res_q;
  unpacked_t           dec_c;

  logic [BEXP_W-1:0]   e_in;
  logic [FRAC_W-1:0]   f_in;
  logic                is_sub;
  logic                accept;
  logic                last_step;
  logic [WORD_W-1:0]   m_nxt;
  logic [CNT_W-1:0]    cnt_nxt;

  assign e_in      = a[62:52];
  assign f_in      = a[51:0];
  assign is_sub    = (e_in == '0) && (f_in != '0);
  assign accept    = (state_q == S_IDLE) && ap_start;
  assign last_step = (state_q == S_NORM) && (step_q == STEP_W'(NORM_STEPS - 1));

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ap_start) state_d = is_sub ? S_NORM : S_DONE;
      S_NORM:  if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NORM step index; restarts on every accept.
  always_ff @(posedge ap_clk) begin
    if (ap_rst)                 step_q <= '0;
    else if (accept)            step_q <= '0;
    else if (state_q == S_NORM) step_q <= step_q + STEP_W'(1);
  end

  float64_subnorm_shifter u_shifter (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .load      (accept && is_sub),
    .frac      (f_in),
    .step      (state_q == S_NORM),
    .step_idx  (step_q),
    .m_nxt_c   (m_nxt),
    .cnt_nxt_c (cnt_nxt)
  );

  // Single-cycle decode for every class except subnormal.
  always_comb begin
    dec_c.sign = a[63];
    dec_c.exp  = '0;
    dec_c.sig  = '0;
    dec_c.cls  = CLS_ZERO;
    if (e_in == EXP_MAX) begin
      dec_c.exp = EXP_W'(EXP_MAX);
      dec_c.sig = WORD_W'(f_in) << 10;
      if (f_in == '0)   dec_c.cls = CLS_INF;
      else if (f_in[51]) dec_c.cls = CLS_QNAN;
      else               dec_c.cls = CLS_SNAN;
    end else if (e_in != '0) begin
      dec_c.exp = EXP_W'(e_in) - EXP_W'(1);
      dec_c.sig = WORD_W'({1'b1, f_in}) << 10;
      dec_c.cls = CLS_NORMAL;
    end else if (f_in != '0) begin
      dec_c.cls = CLS_SUBNORMAL;
    end
  end

  // Result registers; subnormals are written on the final NORM edge.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sign_q    <= 1'b0;
      res_q.sign <= 1'b0;
      res_q.exp  <= '0;
      res_q.sig  <= '0;
      res_q.cls  <= CLS_ZERO;
    end else begin
      if (accept) sign_q <= a[63];
      if (accept && !is_sub) begin
        res_q <= dec_c;
      end else if (last_step) begin
        res_q.sign <= sign_q;
        res_q.exp  <= EXP_W'(0) - EXP_W'(cnt_nxt);
        res_q.sig  <= m_nxt >> 1;
        res_q.cls  <= CLS_SUBNORMAL;
      end
    end
  end

  assign aSign    = res_q.sign;
  assign aExp     = res_q.exp;
  assign aSig     = res_q.sig;
  assign aClass   = res_q.cls;

  assign ap_done  = (state_q == S_DONE);
  assign ap_ready = ap_done;
  assign ap_idle  = (state_q == S_IDLE) && !ap_start;

  assign float_exception_flag_o_ap_vld = ap_done && (res_q.cls == CLS_SNAN);
  assign float_exception_flag_o = float_exception_flag_i |
                                  (float_exception_flag_o_ap_vld ? FLAG_INVALID : '0);

endmodule

// File: tb/tb_unpack_float64.sv
// Self-checking bench for unpack_float64: directed cases, reset during
// normalization, back-to-back starts and random operands compared against
// an arithmetic reference model and a reference packer.
module tb_unpack_float64;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [63:0] a;
  logic [31:0] flag_i, flag_o;
  logic        flag_vld;
  logic        aSign;
  logic [12:0] aExp;
  logic [63:0] aSig;
  logic [2:0]  aClass;

  int n_assert = 0;
  int n_fail   = 0;

  unpack_float64 dut (
    .ap_clk                        (ap_clk),
    .ap_rst                        (ap_rst),
    .ap_start                      (ap_start),
    .ap_done                       (ap_done),
    .ap_idle                       (ap_idle),
    .ap_ready                      (ap_ready),
    .a                             (a),
    .float_exception_flag_i        (flag_i),
    .float_exception_flag_o        (flag_o),
    .float_exception_flag_o_ap_vld (flag_vld),
    .aSign                         (aSign),
    .aExp                          (aExp),
    .aSig                          (aSig),
    .aClass                        (aClass)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Reference unpacker computed directly from the field rules.
  task automatic model(input logic [63:0] x, output logic s, output logic [12:0] e,
                       output logic [63:0] sig, output logic [2:0] cls, output int lat);
    int          ee;
    int          p;
    int          cnt;
    logic [51:0] f;
    ee  = int'(x[62:52]);
    f   = x[51:0];
    s   = x[63];
    lat = 1;
    p   = 0;
    if (ee == 2047) begin
      e   = 13'd2047;
      sig = 64'(f) << 10;
      cls = (f == 0) ? 3'd3 : (f[51] ? 3'd4 : 3'd5);
    end else if (ee != 0) begin
      e   = 13'(ee - 1);
      sig = (64'(f) + (64'd1 << 52)) << 10;
      cls = 3'd2;
    end else if (f == 0) begin
      e   = 13'd0;
      sig = 64'd0;
      cls = 3'd0;
    end else begin
      for (int i = 0; i < 52; i++) if (f[i]) p = i;
      cnt = 52 - p;
      e   = 13'(-cnt);
      sig = 64'(f) << (10 + cnt);
      cls = 3'd1;
      lat = 7;
    end
  endtask

  // Reference packer for exact finite non-zero operands.
  function automatic logic [63:0] pack(input logic s, input logic [12:0] e, input logic [63:0] sig);
    int se;
    se = $signed(e);
    if (se >= 0) return {s, 11'(se + 1), sig[61:10]};
    else         return {s, 11'd0, 52'(sig >> (10 - se))};
  endfunction

  task automatic do_op(input logic [63:0] x, input logic [31:0] fi);
    logic        es;
    logic [12:0] ee;
    logic [63:0] esig;
    logic [2:0]  ecls;
    int          elat;
    int          cycles;
    model(x, es, ee, esig, ecls, elat);
    @(negedge ap_clk);
    a        = x;
    flag_i   = fi;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    a        = ~x;
    cycles   = 1;
    while (ap_done !== 1'b1 && cycles < 20) begin
      @(posedge ap_clk);
      #1;
      cycles++;
    end
    chk("latency", 64'(cycles), 64'(elat));
    chk("ready", 64'(ap_ready), 64'd1);
    chk("sign", 64'(aSign), 64'(es));
    chk("exp", 64'(aExp), 64'(ee));
    chk("sig", aSig, esig);
    chk("class", 64'(aClass), 64'(ecls));
    chk("flag_o_done", 64'(flag_o), 64'(fi | ((ecls == 3'd5) ? 32'd16 : 32'd0)));
    chk("vld_done", 64'(flag_vld), 64'(ecls == 3'd5));
    if (ecls == 3'd1 || ecls == 3'd2)
      chk("roundtrip", pack(aSign, aExp, aSig), x);
    @(posedge ap_clk);
    #1;
    chk("done_after", 64'(ap_done), 64'd0);
    chk("vld_after", 64'(flag_vld), 64'd0);
    chk("flag_o_after", 64'(flag_o), 64'(fi));
    chk("idle_after", 64'(ap_idle), 64'd1);
  endtask

  initial begin
    logic [63:0] ops [2];
    logic [63:0] x;
    logic        seen;
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    a        = '0;
    flag_i   = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_done", 64'(ap_done), 64'd0);
    chk("rst_idle", 64'(ap_idle), 64'd1);
    chk("rst_sig", aSig, 64'd0);
    chk("rst_class", 64'(aClass), 64'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    // Directed cases.
    do_op(64'h3FF0000000000000, 32'h0);
    chk("one_exp_const", 64'(aExp), 64'h3FE);
    chk("one_sig_const", aSig, 64'h4000000000000000);
    do_op(64'h0000000000000001, 32'h0);
    chk("min_sub_exp_const", 64'(aExp), 64'h1FCC);
    do_op(64'h000FFFFFFFFFFFFF, 32'h0);
    chk("max_sub_sig_const", aSig, 64'h7FFFFFFFFFFFF800);
    do_op(64'h7FF0000000000001, 32'h1);
    do_op(64'h7FF8000000000000, 32'h1);
    do_op(64'h8000000000000000, 32'h0);
    do_op(64'hFFF0000000000000, 32'h4);
    do_op(64'h7FEFFFFFFFFFFFFF, 32'h0);
    do_op(64'h0010000000000000, 32'h0);
    do_op(64'hC000000000000000, 32'h0);

    // Reset during the third NORM cycle discards the result.
    @(negedge ap_clk);
    a        = 64'h0000000000000001;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    @(posedge ap_clk);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("mid_rst_done", 64'(ap_done), 64'd0);
    chk("mid_rst_idle", 64'(ap_idle), 64'd1);
    chk("mid_rst_sign", 64'(aSign), 64'd0);
    chk("mid_rst_exp", 64'(aExp), 64'd0);
    chk("mid_rst_sig", aSig, 64'd0);
    chk("mid_rst_class", 64'(aClass), 64'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    seen   = 1'b0;
    repeat (10) begin
      @(posedge ap_clk);
      #1;
      seen = seen | ap_done;
    end
    chk("mid_rst_no_done", 64'(seen), 64'd0);
    do_op(64'h000000000000F00D, 32'h8);

    // Back-to-back starts alternating 1.0 and -2.0.
    ops[0] = 64'h3FF0000000000000;
    ops[1] = 64'hC000000000000000;
    @(negedge ap_clk);
    flag_i   = 32'h0;
    a        = ops[0];
    ap_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge ap_clk);
      #1;
      chk("b2b_done", 64'(ap_done), 64'd1);
      chk("b2b_sign", 64'(aSign), 64'(i % 2));
      chk("b2b_exp", 64'(aExp), (i % 2 == 0) ? 64'h3FE : 64'h3FF);
      chk("b2b_sig", aSig, 64'h4000000000000000);
      a = ops[(i + 1) % 2];
      @(posedge ap_clk);
      #1;
      chk("b2b_gap", 64'(ap_done), 64'd0);
    end
    ap_start = 1'b0;

    // Random operands across all classes.
    for (int i = 0; i < 60; i++) begin
      x = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0, 1: x[62:52] = 11'd0;
        2:    x[62:52] = 11'h7FF;
        default: ;
      endcase
      do_op(x, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
